sync_tracker: RTL and testbench

Parametrised successor to the per-axis sync capture counter in the CGA capture path. It adds:
- a glitch filter on the incoming sync;
- automatic sync-polarity detection;
- sync period measurement;
- a period lock state machine.

One instance sits per axis, as the horizontal or vertical tracker. Its address and valid outputs drive the sampler and frame-buffer write port, and cascade_enable steps the next axis.

---
 rtl/sync_tracker.sv | 155 +++++++++++++++
 tb/tb_sync_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_tracker.sv
// Per-axis sync tracker: glitch-filtered sync, polarity detection, period measurement and lock FSM.
// Edge accepted FILTER-1 enabled cycles after its first sample; no backpressure, enable only qualifies state updates.
module sync_tracker #(
  parameter int CNT_W      = 16,
  parameter int OFFSET     = 'h48e,
  parameter int VALID      = 5120,
  parameter int FILTER     = 3,
  parameter int AUTO_POL   = 1,
  parameter int SYNC_POL   = 1,
  parameter int TOL        = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_in,
  output logic             valid,
  output logic             cascade_enable,
  output logic [CNT_W-1:0] address,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             polarity
);

  localparam int DIS_W = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int MC_W  = $clog2(LOCK_COUNT + 1);

  localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(FILTER - 1);
  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W:0]   WIN_LO   = (CNT_W+1)'(OFFSET);
  localparam logic [CNT_W:0]   WIN_HI   = (CNT_W+1)'(OFFSET + VALID);
  localparam logic [CNT_W-1:0] OFS      = CNT_W'(OFFSET);
  localparam logic [CNT_W-1:0] TOL_V    = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             POL_RST  = 1'(SYNC_POL);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] hi_cnt;
  logic [CNT_W-1:0] lo_cnt;
  logic [DIS_W-1:0] dis_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic             sync_f;

  logic             differ;
  logic             accept;
  logic             active_edge;
  logic             rise;
  logic             sat;
  logic             match;
  logic             new_pol;
  logic             pol_change;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] per_diff;

  always_comb begin
    differ      = sync_in != sync_f;
    accept      = enable && differ && (dis_cnt == DIS_LAST);
    active_edge = accept && (sync_in == polarity);
    rise        = accept && sync_in;
    sat         = counter == CNT_MAX;
    cnt_inc     = sat ? counter : counter + 1'b1;
    per_diff    = (cnt_inc >= period) ? cnt_inc - period : period - cnt_inc;
    match       = per_diff <= TOL_V;
    new_pol     = polarity;
    // Active level is whichever level the sync spent less time at over the last period
    if (AUTO_POL != 0 && rise) new_pol = hi_cnt <= lo_cnt;
    pol_change  = new_pol != polarity;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter        <= '0;
      period         <= '0;
      sync_f         <= ~POL_RST;
      dis_cnt        <= '0;
      hi_cnt         <= '0;
      lo_cnt         <= '0;
      polarity       <= POL_RST;
      state          <= SEARCH;
      match_cnt      <= '0;
      cascade_enable <= 1'b0;
    end else begin
      cascade_enable <= 1'b0;
      if (enable) begin
        cascade_enable <= active_edge;

        if (!differ) begin
          dis_cnt <= '0;
        end else if (accept) begin
          sync_f  <= sync_in;
          dis_cnt <= '0;
        end else begin
          dis_cnt <= dis_cnt + 1'b1;
        end

        counter <= active_edge ? '0 : cnt_inc;
        if (active_edge && state != SEARCH) period <= cnt_inc;

        if (AUTO_POL != 0) begin
          if (rise) begin
            polarity <= new_pol;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
          end else if (sync_f) begin
            if (hi_cnt != CNT_MAX) hi_cnt <= hi_cnt + 1'b1;
          end else begin
            if (lo_cnt != CNT_MAX) lo_cnt <= lo_cnt + 1'b1;
          end
        end

        // Priority: polarity change, then active edge, then timeout
        if (pol_change) begin
          state     <= SEARCH;
          match_cnt <= '0;
        end else if (active_edge) begin
          case (state)
            SEARCH: begin
              state     <= TRACK;
              match_cnt <= '0;
            end
            TRACK: begin
              if (match) begin
                match_cnt <= match_cnt + 1'b1;
                if (match_cnt == MC_LAST) state <= LOCKED;
              end else begin
                match_cnt <= '0;
              end
            end
            LOCKED: begin
              if (!match) begin
                state     <= TRACK;
                match_cnt <= '0;
              end
            end
            default: begin
              state     <= SEARCH;
              match_cnt <= '0;
            end
          endcase
        end else if (sat) begin
          state     <= SEARCH;
          match_cnt <= '0;
        end
      end
    end
  end

  assign valid   = (state != SEARCH) && ({1'b0, counter} >= WIN_LO) && ({1'b0, counter} < WIN_HI);
  assign address = counter - OFS;
  assign locked  = state == LOCKED;

endmodule

// File: tb/tb_sync_tracker.sv
// Directed bench for sync_tracker: filter, lock, auto polarity, timeout, enable gating and reset.
module tb_sync_tracker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic sa = 1'b0, sb = 1'b0, sc = 1'b0, sd = 1'b0;

  logic a_valid, a_casc, a_locked, a_pol;
  logic [15:0] a_addr, a_period;
  logic b_valid, b_casc, b_locked, b_pol;
  logic [15:0] b_addr, b_period;
  logic c_valid, c_casc, c_locked, c_pol;
  logic [7:0] c_addr, c_period;
  logic d_valid, d_casc, d_locked, d_pol;
  logic [15:0] d_addr, d_period;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_tracker #(.CNT_W(16), .OFFSET(4), .VALID(8), .FILTER(3), .AUTO_POL(0), .SYNC_POL(1), .TOL(2), .LOCK_COUNT(4)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .sync_in(sa), .valid(a_valid), .cascade_enable(a_casc),
    .address(a_addr), .period(a_period), .locked(a_locked), .polarity(a_pol));

  sync_tracker #(.CNT_W(16), .OFFSET(4), .VALID(8), .FILTER(3), .AUTO_POL(1), .SYNC_POL(1), .TOL(2), .LOCK_COUNT(4)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .sync_in(sb), .valid(b_valid), .cascade_enable(b_casc),
    .address(b_addr), .period(b_period), .locked(b_locked), .polarity(b_pol));

  sync_tracker #(.CNT_W(8), .OFFSET(4), .VALID(8), .FILTER(3), .AUTO_POL(0), .SYNC_POL(1), .TOL(2), .LOCK_COUNT(4)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .sync_in(sc), .valid(c_valid), .cascade_enable(c_casc),
    .address(c_addr), .period(c_period), .locked(c_locked), .polarity(c_pol));

  sync_tracker u_d (
    .clk(clk), .reset(reset), .enable(enable), .sync_in(sd), .valid(d_valid), .cascade_enable(d_casc),
    .address(d_addr), .period(d_period), .locked(d_locked), .polarity(d_pol));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One sync period on instance A: 20 cycles high, then low for the rest
  task automatic pulse_a(input int len);
    sa = 1'b1;
    repeat (20) tick();
    sa = 1'b0;
    repeat (len - 20) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    sa = 1'b0; sb = 1'b0; sc = 1'b0; sd = 1'b0;
    tick();
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got=%b exp=0", a_valid); end
    checks++; if (a_casc !== 1'b0) begin errors++; $display("FAIL rst_a_casc got=%b exp=0", a_casc); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL rst_a_locked got=%b exp=0", a_locked); end
    checks++; if (a_period !== 16'd0) begin errors++; $display("FAIL rst_a_period got=%h exp=0", a_period); end
    checks++; if (a_pol !== 1'b1) begin errors++; $display("FAIL rst_a_pol got=%b exp=1", a_pol); end
    checks++; if (a_addr !== 16'hfffc) begin errors++; $display("FAIL rst_a_addr got=%h exp=fffc", a_addr); end
    checks++; if (b_pol !== 1'b1) begin errors++; $display("FAIL rst_b_pol got=%b exp=1", b_pol); end
    checks++; if (c_addr !== 8'hfc) begin errors++; $display("FAIL rst_c_addr got=%h exp=fc", c_addr); end
    checks++; if (d_addr !== 16'hfb72) begin errors++; $display("FAIL rst_d_addr got=%h exp=fb72", d_addr); end
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
    reset = 1'b0;
  endtask

  task automatic test_filter();
    enable = 1'b1; sa = 1'b0;
    do_reset();
    repeat (5) tick();
    for (int i = 0; i < 12; i++) begin
      sa = (i < 2);
      tick();
      checks++; if (a_casc !== 1'b0) begin errors++; $display("FAIL glitch_casc t=%0d got=%b exp=0", i, a_casc); end
    end
    checks++; if (a_addr !== 16'd13) begin errors++; $display("FAIL glitch_addr got=%h exp=000d", a_addr); end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 100; i++) begin
        sa = (i < 20);
        tick();
        checks++; if (a_casc !== (i == 2)) begin errors++; $display("FAIL filt_casc p=%0d i=%0d got=%b exp=%b", p, i, a_casc, (i == 2)); end
        checks++; if (a_valid !== (i >= 6 && i <= 13)) begin errors++; $display("FAIL filt_valid p=%0d i=%0d got=%b", p, i, a_valid); end
        if (i >= 2) begin
          checks++; if (a_addr !== 16'(i - 6)) begin errors++; $display("FAIL filt_addr p=%0d i=%0d got=%h exp=%h", p, i, a_addr, 16'(i - 6)); end
        end
      end
      checks++; if (a_period !== 16'((p == 0) ? 0 : 100)) begin errors++; $display("FAIL filt_period p=%0d got=%0d", p, a_period); end
    end
  endtask

  task automatic test_lock();
    int lens [9];
    int exp_p [9];
    int exp_l [9];
    lens  = '{100, 100, 99, 101, 100, 99, 101, 130, 100};
    exp_p = '{0, 100, 100, 99, 101, 100, 99, 101, 130};
    exp_l = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
    enable = 1'b1; sa = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      pulse_a(lens[k]);
      checks++; if (a_locked !== 1'(exp_l[k])) begin errors++; $display("FAIL lock_locked edge=%0d got=%b exp=%0d", k + 1, a_locked, exp_l[k]); end
      checks++; if (a_period !== 16'(exp_p[k])) begin errors++; $display("FAIL lock_period edge=%0d got=%0d exp=%0d", k + 1, a_period, exp_p[k]); end
    end
  endtask

  task automatic test_auto_pol();
    int vi;
    enable = 1'b1; sb = 1'b0;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      vi = (p == 2) ? 8 : 16;
      for (int i = 0; i < 100; i++) begin
        sb = (i >= 8);
        tick();
        checks++; if (b_casc !== ((p < 2 && i == 10) || (p == 2 && i == 2))) begin errors++; $display("FAIL pol_casc p=%0d i=%0d got=%b", p, i, b_casc); end
        if (i == 11) begin
          checks++; if (b_pol !== (p == 0)) begin errors++; $display("FAIL pol_level p=%0d got=%b exp=%b", p, b_pol, (p == 0)); end
        end
        if (i == vi) begin
          checks++; if (b_valid !== (p != 1)) begin errors++; $display("FAIL pol_valid p=%0d got=%b exp=%b", p, b_valid, (p != 1)); end
        end
      end
    end
    sb = 1'b0;
  endtask

  task automatic test_timeout();
    enable = 1'b1; sc = 1'b0;
    do_reset();
    sc = 1'b1; repeat (20) tick();
    sc = 1'b0; repeat (30) tick();
    sc = 1'b1; repeat (20) tick();
    checks++; if (c_period !== 8'd50) begin errors++; $display("FAIL to_period1 got=%0d exp=50", c_period); end
    sc = 1'b0; repeat (300) tick();
    checks++; if (c_addr !== 8'hfb) begin errors++; $display("FAIL to_sat_addr got=%h exp=fb", c_addr); end
    checks++; if (c_valid !== 1'b0) begin errors++; $display("FAIL to_sat_valid got=%b exp=0", c_valid); end
    checks++; if (c_locked !== 1'b0) begin errors++; $display("FAIL to_sat_locked got=%b exp=0", c_locked); end
    sc = 1'b1; repeat (3) tick();
    checks++; if (c_casc !== 1'b1) begin errors++; $display("FAIL to_edge_casc got=%b exp=1", c_casc); end
    checks++; if (c_addr !== 8'hfc) begin errors++; $display("FAIL to_edge_addr got=%h exp=fc", c_addr); end
    checks++; if (c_period !== 8'd50) begin errors++; $display("FAIL to_search_period got=%0d exp=50", c_period); end
    repeat (4) tick();
    checks++; if (c_valid !== 1'b1) begin errors++; $display("FAIL to_track_valid got=%b exp=1", c_valid); end
    checks++; if (c_addr !== 8'h00) begin errors++; $display("FAIL to_track_addr got=%h exp=00", c_addr); end
    repeat (13) tick();
    sc = 1'b0; repeat (40) tick();
    sc = 1'b1; repeat (3) tick();
    checks++; if (c_casc !== 1'b1) begin errors++; $display("FAIL to_edge2_casc got=%b exp=1", c_casc); end
    checks++; if (c_period !== 8'd60) begin errors++; $display("FAIL to_period2 got=%0d exp=60", c_period); end
    sc = 1'b0;
  endtask

  task automatic test_enable();
    int exp_cnt;
    enable = 1'b1; sa = 1'b0;
    do_reset();
    sa = 1'b1;
    for (int n = 0; n < 40; n++) begin
      enable = (n % 4 == 0);
      tick();
      exp_cnt = (n < 8) ? (n / 4 + 1) : ((n - 8) / 4);
      checks++; if (a_casc !== (n == 8)) begin errors++; $display("FAIL en_casc n=%0d got=%b exp=%b", n, a_casc, (n == 8)); end
      checks++; if (a_addr !== 16'(exp_cnt - 4)) begin errors++; $display("FAIL en_addr n=%0d got=%h exp=%h", n, a_addr, 16'(exp_cnt - 4)); end
    end
    enable = 1'b1; sa = 1'b0;
  endtask

  task automatic test_reset_mid();
    enable = 1'b1; sa = 1'b0;
    do_reset();
    repeat (6) pulse_a(100);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL mid_pre_locked got=%b exp=1", a_locked); end
    sa = 1'b1;
    repeat (10) tick();
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", a_valid); end
    checks++; if (a_addr !== 16'd3) begin errors++; $display("FAIL mid_pre_addr got=%h exp=0003", a_addr); end
    reset = 1'b1; enable = 1'b0;
    tick();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", a_valid); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL mid_locked got=%b exp=0", a_locked); end
    checks++; if (a_period !== 16'd0) begin errors++; $display("FAIL mid_period got=%0d exp=0", a_period); end
    checks++; if (a_pol !== 1'b1) begin errors++; $display("FAIL mid_pol got=%b exp=1", a_pol); end
    checks++; if (a_addr !== 16'hfffc) begin errors++; $display("FAIL mid_addr got=%h exp=fffc", a_addr); end
    checks++; if (d_addr !== 16'hfb72) begin errors++; $display("FAIL mid_d_addr got=%h exp=fb72", d_addr); end
    checks++; if (d_pol !== 1'b1) begin errors++; $display("FAIL mid_d_pol got=%b exp=1", d_pol); end
    reset = 1'b0; enable = 1'b1; sa = 1'b0;
  endtask

  initial begin
    test_reset();
    test_filter();
    test_lock();
    test_auto_pol();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
